// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg
//   Types and constants shared by the LC-3 memory responder and its storage
//   array: read FSM state encoding, bus widths, reset constants and the
//   address range helper.
package lc3_mem_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [WORD_W-1:0] RDATA_RST = '0;
    localparam logic [15:0]       COUNT_RST = '0;

    // True when every address bit above the implemented width is zero.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int aw);
        return (addr >> aw) == '0;
    endfunction

endpackage

// File: rtl/lc3_mem_array.sv
// lc3_mem_array
//   2^AW x WORD_W word storage. One synchronous write port and one
//   asynchronous read port; the parent registers the read data at its
//   sampling edge and applies the write-first bypass itself.
// Ports:
//   clk    - clock
//   we     - write enable (already qualified by the parent)
//   waddr  - write word address
//   wdata  - write data
//   raddr  - read word address
//   rdata  - read data (contents before any write on the current edge)
module lc3_mem_array
    import lc3_mem_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**AW];

    // NOTE: the storage array is deliberately not reset; clearing 2^AW words
    // would force it out of RAM into flops, and the contents are preloaded
    // by the environment anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder
//   Target side of the LC-3 memory bus. Writes commit in the cycle they are
//   strobed; reads complete RD_LAT cycles after mem_re is first sampled with
//   a one-cycle mem_ready pulse. Counts completed reads and committed CPU
//   writes, and raises sticky protocol and address-range error flags.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   mem_addr               - CPU word address (reads and writes)
//   mem_we, mem_wdata      - CPU single-cycle write strobe and data
//   mem_re                 - CPU read request, held until mem_ready
//   mem_ready, mem_rdata   - read-complete pulse and read data
//   load_we/addr/wdata     - environment preload port (wins over mem_we)
//   rd_count, wr_count     - completed reads / committed CPU writes, wrapping
//   proto_err, addr_err    - sticky protocol / out-of-range flags
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int AW     = 16,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mem_addr,
    input  logic        mem_we,
    input  logic [15:0] mem_wdata,
    input  logic        mem_re,
    output logic        mem_ready,
    output logic [15:0] mem_rdata,
    input  logic        load_we,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_wdata,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        proto_err,
    output logic        addr_err
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t            state;
    logic [CNT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ok;

    logic              cpu_addr_ok;
    logic              load_addr_ok;
    logic              load_commit;
    logic              cpu_commit;
    logic              arr_we;
    logic [AW-1:0]     arr_waddr;
    logic [WORD_W-1:0] arr_wdata;
    logic [WORD_W-1:0] arr_rdata;
    logic [ADDR_W-1:0] samp_addr;
    logic              samp_ok;
    logic [WORD_W-1:0] samp_data;

    assign cpu_addr_ok  = addr_in_range(mem_addr, AW);
    assign load_addr_ok = addr_in_range(load_addr, AW);

    // The preload port owns the single write port whenever it strobes; a CPU
    // write in the same cycle is dropped.
    assign load_commit = load_we && load_addr_ok;
    assign cpu_commit  = mem_we && !load_we && cpu_addr_ok;

    assign arr_we    = load_commit || cpu_commit;
    assign arr_waddr = load_commit ? load_addr[AW-1:0] : mem_addr[AW-1:0];
    assign arr_wdata = load_commit ? load_wdata : mem_wdata;

    // With a single-cycle latency the array is sampled at the IDLE edge from
    // the live bus address; otherwise from the latched read address.
    assign samp_addr = (state == IDLE) ? mem_addr : rd_addr;
    assign samp_ok   = (state == IDLE) ? cpu_addr_ok : rd_ok;

    lc3_mem_array #(.AW(AW)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .raddr (samp_addr[AW-1:0]),
        .rdata (arr_rdata)
    );

    // Write-first bypass: a write landing on the sampled word at the sampling
    // edge is returned instead of the stale array contents. Out-of-range
    // reads return zero.
    // NOTE: samp_data gets its default before any conditional override so
    // every path assigns it and no latch is inferred.
    always_comb begin
        samp_data = arr_rdata;
        if (arr_we && (arr_waddr == samp_addr[AW-1:0])) begin
            samp_data = arr_wdata;
        end
        if (!samp_ok) begin
            samp_data = '0;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // sees the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            rd_addr   <= '0;
            rd_ok     <= 1'b0;
            mem_ready <= 1'b0;
            mem_rdata <= RDATA_RST;
            rd_count  <= COUNT_RST;
            wr_count  <= COUNT_RST;
            proto_err <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            mem_ready <= 1'b0;

            if (cpu_commit) begin
                wr_count <= wr_count + 16'd1;
            end
            if (mem_we && load_we) begin
                proto_err <= 1'b1;
            end
            if (((mem_we || mem_re) && !cpu_addr_ok) || (load_we && !load_addr_ok)) begin
                addr_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (mem_re) begin
                        rd_addr <= mem_addr;
                        rd_ok   <= cpu_addr_ok;
                        if (mem_we) begin
                            proto_err <= 1'b1;
                        end
                        if (RD_LAT == 1) begin
                            mem_rdata <= samp_data;
                            mem_ready <= 1'b1;
                            rd_count  <= rd_count + 16'd1;
                            state     <= RESP;
                        end else begin
                            lat_cnt <= CNT_W'(RD_LAT - 1);
                            state   <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (!mem_re) begin
                        // Requester gave up: abandon the read silently.
                        proto_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        if (mem_addr != rd_addr) begin
                            proto_err <= 1'b1;
                        end
                        if (lat_cnt == CNT_W'(1)) begin
                            mem_rdata <= samp_data;
                            mem_ready <= 1'b1;
                            rd_count  <= rd_count + 16'd1;
                            state     <= RESP;
                        end else begin
                            lat_cnt <= lat_cnt - CNT_W'(1);
                        end
                    end
                end

                RESP: begin
                    // mem_re is ignored here; a still-high request restarts
                    // from IDLE on the next edge.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lc3_mem_responder.md
# lc3_mem_responder

Synthesizable memory responder for the LC-3 memory interface: the target end of the `mem_addr`/`mem_we`/`mem_re`/`mem_ready`/`mem_rdata` protocol driven by the CPU. It sits behind the virtual interface in the SV test environment, next to the passive memory monitor. It holds program and data words, including the bubble-sort image, and serves reads with a programmable latency. It also counts transactions and flags protocol violations.

## Interface
- `AW`, 16: implemented address bits; the array holds 2^AW words. Legal range is 1..16.
- `RD_LAT`, 2: read latency in cycles. Minimum 1.
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_addr` in 16: word address.
- `mem_we` in 1: single-cycle write strobe.
- `mem_wdata` in 16: write data.
- `mem_re` in 1: read request; held high until `mem_ready`.
- `mem_ready` out 1: one-cycle read-complete pulse.
- `mem_rdata` out 16: read data; valid only while `mem_ready` is high.
- `load_we` in 1: bench preload strobe.
- `load_addr` in 16: preload address.
- `load_wdata` in 16: preload data.
- `rd_count` out 16: completed reads; wraps.
- `wr_count` out 16: committed CPU writes; wraps. Preloads are not counted.
- `proto_err` out 1: sticky protocol-violation flag.
- `addr_err` out 1: sticky out-of-range flag.

## Operation
- **Reset values.** `mem_ready`=0, `mem_rdata`=0, both counts=0, both error flags=0, state=IDLE. Array contents are not reset.
- **Writes.**
  - With `mem_we`=1 at an edge, `mem_wdata` is committed to `mem_addr` at that edge and `wr_count` increments.
  - Writes get no `mem_ready`.
  - Writes are accepted in every state.
- **Preload.**
  - With `load_we`=1, `load_wdata` is committed to `load_addr`.
  - If `load_we` and `mem_we` are both 1 in the same cycle: the preload wins, the CPU write is dropped and not counted, and `proto_err` is set.
- **Read FSM.** States are IDLE, WAIT and RESP.
  - IDLE → `mem_re`=1: latch `mem_addr` into `rd_addr`.
    - RD_LAT=1: go to RESP.
    - Otherwise: load the counter with RD_LAT-1 and go to WAIT.
  - WAIT: decrement the counter each cycle. At the edge where the counter is 1, sample the array at `rd_addr` into `mem_rdata` and go to RESP.
  - RD_LAT=1: the array is sampled at the IDLE edge itself.
  - RESP: `mem_ready`=1 for exactly one cycle and `rd_count` increments. Return to IDLE unconditionally; `mem_re` is ignored at this edge.
  - A `mem_re` still high in the following IDLE cycle starts a new read (back-to-back reads are legal).
- **Write/read collision.** If a write (CPU or preload) to `rd_addr` commits on the sampling edge, `mem_rdata` takes the new write data (write-first bypass).
- **Protocol errors.** All of these set `proto_err`:
  - `mem_re` drops while in WAIT: abort to IDLE, no `mem_ready`, count unchanged.
  - `mem_addr` differs from `rd_addr` while in WAIT with `mem_re`=1: continue using `rd_addr`.
  - `mem_we` and `mem_re` both high in IDLE: the write commits and the read still starts.
- **Range errors.** Any `mem_addr`/`load_addr` with nonzero bits [15:AW] on an active strobe sets `addr_err`.
  - The write is dropped and not counted.
  - A read completes normally with `mem_rdata`=16'h0000.
- **`mem_rdata` between reads.** Holds its last value.
- **Reset during a read.** An asynchronous `rst_n` low in WAIT or RESP returns to IDLE immediately, with `mem_ready` low in the same cycle.

## Timing
- `mem_re` is first sampled at edge E0. `mem_ready` and `mem_rdata` become valid after edge E0+RD_LAT-1 and are high for one cycle only.
- Minimum spacing between read starts is RD_LAT+1 cycles.
- Write latency is 0: data is readable by a read whose sampling edge is the same edge or later.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- **`lc3_mem_pkg`** holds:
  - the `state_t` enum (IDLE, WAIT, RESP);
  - `WORD_W`=16;
  - `ADDR_W`=16;
  - the reset constants for `mem_rdata` and the counts.
- **`lc3_mem_array`** is the one sub-module: 2^AW x 16, one synchronous write port, one read port used at the sampling edge. The bypass mux lives in the parent.
- **Parent (`lc3_mem_responder`)** contains the FSM, latency counter, transaction counters and error flags.

## Test plan
- **Preload then read, RD_LAT=2.** Preload 0x3000←0x1234, then hold `mem_re` at 0x3000. Required: `mem_ready` exactly one cycle, 2 cycles after the first sample; `rdata`=0x1234; `rd_count`=1.
- **Back-to-back reads.** Hold `mem_re` continuously across 0x3000 and 0x3001 (0xBEEF). Required: two ready pulses 3 cycles apart, data 0x1234 then 0xBEEF, `proto_err`=0.
- **Write-first bypass.** Start a read at 0x4000 (old 0x0000) and `mem_we` 0x4000←0x00AA on the sampling edge. Required: `rdata`=0x00AA, `wr_count`=1.
- **Abort.** Drop `mem_re` 1 cycle into WAIT. Required: no `mem_ready`, `rd_count` unchanged, `proto_err`=1 until reset.
- **Out of range, AW=12.** Write 0x1000←0x5555. Required: `addr_err`=1, `wr_count`=0, and a read of 0x1000 returns 0x0000.
- **Reset mid-read.** Assert `rst_n`=0 in WAIT. Required: `mem_ready`=0 immediately; counts and flags zero; a new read after release completes normally.
